uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer on RX, mid-bit sampling FSM,
// frame format start(0) + DATA_W bits MSB first + stop(1).
// Good words are held in RX_DATA/RX_READY until acknowledged.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_rx #(
   parameter int DATA_W   = 8,
   parameter int BAUD_DIV = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RX,
   input  logic              RX_ACK,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              RX_READY,
   output logic              FRAME_ERR,
   output logic              OVERRUN,
   output logic              BUSY
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // First sample lands mid start bit; later samples one full period apart.
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t              state_q, state_d;
   logic                rx_meta_q, rx_s_q;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                rdy_q, rdy_d;
   logic                fe_q, fe_d;
   logic                ov_q, ov_d;

   // Two-flop synchronizer; resets to the idle (high) line level so that a
   // reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   // Next-state, sampling and output-word logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      data_d  = data_q;
      // An acknowledge only matters while a word is pending.
      rdy_d   = rdy_q & ~RX_ACK;
      fe_d    = 1'b0;
      ov_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d = DATA;
                  bit_d   = '0;
               end else begin
                  // Line went back high before mid start bit: a glitch.
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               // Left shift with new bit at LSB: first bit ends up at MSB.
               sh_d  = DATA_W'({sh_q, rx_s_q});
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = sh_q;
                  rdy_d   = 1'b1;
                  // A same-edge acknowledge consumes the old word: no overrun.
                  ov_d    = rdy_q & ~RX_ACK;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         BREAK: begin
            // Wait out a held-low line so it is not taken as a new start bit.
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign RX_DATA   = data_q;
   assign RX_READY  = rdy_q;
   assign FRAME_ERR = fe_q;
   assign OVERRUN   = ov_q;
   assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx against a frame-level reference model:
// expected word, ready flag and pulse counts are derived per frame from the
// frame contents, acknowledge timing and the fixed reception latency.
module tb_uart_rx;

   localparam int D   = 8;
   localparam int B   = 16;
   localparam int LAT = 2 + B / 2 + (D + 1) * B;

   logic         clk;
   logic         rst;
   logic         RX;
   logic         RX_ACK;
   logic [D-1:0] RX_DATA;
   logic         RX_READY;
   logic         FRAME_ERR;
   logic         OVERRUN;
   logic         BUSY;

   int total = 0;
   int bad   = 0;

   // model state
   logic [D-1:0] exp_data  = '0;
   logic         exp_ready = 1'b0;

   int  fe_cnt  = 0;
   int  ov_cnt  = 0;
   logic fe_prev = 1'b0;
   logic ov_prev = 1'b0;

   uart_rx #(.DATA_W(D), .BAUD_DIV(B)) dut (
      .clk      (clk),
      .rst      (rst),
      .RX       (RX),
      .RX_ACK   (RX_ACK),
      .RX_DATA  (RX_DATA),
      .RX_READY (RX_READY),
      .FRAME_ERR(FRAME_ERR),
      .OVERRUN  (OVERRUN),
      .BUSY     (BUSY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Pulse monitor: counts events and checks they never last two cycles.
   always @(negedge clk) begin
      if (FRAME_ERR) begin
         fe_cnt++;
         chk("fe_width", 32'(fe_prev), 32'(0));
      end
      if (OVERRUN) begin
         ov_cnt++;
         chk("ov_width", 32'(ov_prev), 32'(0));
      end
      fe_prev = FRAME_ERR;
      ov_prev = OVERRUN;
   end

   // Line level for bit-period k of a frame: start, data MSB first, stop.
   function automatic logic bit_at(input logic [D-1:0] d, input logic stopb, input int k);
      if (k == 0) return 1'b0;
      if (k <= D) return d[D-k];
      return stopb;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         RX = 1'b1;
      end
   endtask

   // ack_mode: 0 none, 1 acknowledge before the frame, 2 acknowledge on the
   // completion edge. hold_low: extra low cycles after a bad stop bit.
   task automatic send_frame(input logic [D-1:0] d, input logic stopb,
                             input int ack_mode, input int hold_low);
      int  fe0, ov0;
      logic exp_ov;
      if (ack_mode == 1) begin
         @(negedge clk); RX_ACK = 1'b1;
         @(negedge clk); RX_ACK = 1'b0;
         exp_ready = 1'b0;
         chk("ack_clr", 32'(RX_READY), 32'(0));
      end
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      exp_ov = stopb && exp_ready && (ack_mode != 2);
      for (int i = 0; i < 10 * B; i++) begin
         @(negedge clk);
         if (i == 3) chk("busy_start", 32'(BUSY), 32'(1));
         if (i == 5 * B) chk("busy_mid", 32'(BUSY), 32'(1));
         if (i == LAT) begin
            chk("pre_rdy", 32'(RX_READY), 32'(exp_ready));
            chk("pre_fe", 32'(FRAME_ERR), 32'(0));
            chk("busy_stop", 32'(BUSY), 32'(1));
            if (ack_mode == 2) RX_ACK = 1'b1;
         end
         if (i == LAT + 1) begin
            RX_ACK = 1'b0;
            if (stopb) begin
               exp_ready = 1'b1;
               exp_data  = d;
            end else if (ack_mode == 2) begin
               exp_ready = 1'b0;
            end
            chk("data", 32'(RX_DATA), 32'(exp_data));
            chk("ready", 32'(RX_READY), 32'(exp_ready));
            chk("fe_pulse", 32'(FRAME_ERR), 32'(!stopb));
            chk("ov_pulse", 32'(OVERRUN), 32'(exp_ov));
         end
         RX = bit_at(d, stopb, i / B);
      end
      if (!stopb) begin
         repeat (hold_low) begin
            @(negedge clk);
            RX = 1'b0;
         end
         @(negedge clk);
         chk("busy_break", 32'(BUSY), 32'(1));
         RX = 1'b1;
         idle(6);
         chk("break_exit", 32'(BUSY), 32'(0));
         chk("break_rdy", 32'(RX_READY), 32'(exp_ready));
         chk("break_data", 32'(RX_DATA), 32'(exp_data));
      end
      chk("fe_count", 32'(fe_cnt - fe0), 32'(!stopb));
      chk("ov_count", 32'(ov_cnt - ov0), 32'(exp_ov));
   endtask

   task automatic glitch(input int len);
      int fe0, ov0;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      repeat (len) begin
         @(negedge clk);
         RX = 1'b0;
      end
      idle(20);
      chk("gl_busy", 32'(BUSY), 32'(0));
      chk("gl_rdy", 32'(RX_READY), 32'(exp_ready));
      chk("gl_data", 32'(RX_DATA), 32'(exp_data));
      chk("gl_fe", 32'(fe_cnt - fe0), 32'(0));
      chk("gl_ov", 32'(ov_cnt - ov0), 32'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data"}, 32'(RX_DATA), 32'(0));
      chk({tag, "_rdy"}, 32'(RX_READY), 32'(0));
      chk({tag, "_fe"}, 32'(FRAME_ERR), 32'(0));
      chk({tag, "_ov"}, 32'(OVERRUN), 32'(0));
      chk({tag, "_busy"}, 32'(BUSY), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [D-1:0] ff_word;
      ff_word = '1;
      rst    = 1'b0;
      RX     = 1'b1;
      RX_ACK = 1'b0;
      #2;
      check_reset_outputs("rst0");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle(5);

      // directed cases
      send_frame(8'hA5, 1'b1, 0, 0);
      glitch(3);
      send_frame(8'h3C, 1'b0, 0, 40);
      send_frame(8'h11, 1'b1, 1, 0);
      idle(4);
      send_frame(8'h22, 1'b1, 0, 0);
      idle(4);
      send_frame(8'h5A, 1'b1, 2, 0);
      idle(4);

      // reset midway through the data bits of 0xFF
      for (int i = 0; i < 5 * B; i++) begin
         @(negedge clk);
         RX = bit_at(ff_word, 1'b1, i / B);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      RX = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_hold");
      rst = 1'b1;
      exp_ready = 1'b0;
      exp_data  = '0;
      idle(5);
      chk("rst_idle", 32'(BUSY), 32'(0));
      send_frame(8'h0F, 1'b1, 0, 0);
      idle(3);

      // randomized frames
      for (int n = 0; n < 30; n++) begin
         logic [D-1:0] d;
         logic         sb;
         d  = D'($urandom);
         sb = ($urandom_range(0, 3) != 0);
         send_frame(d, sb, int'($urandom_range(0, 2)), int'($urandom_range(1, 40)));
         idle(int'($urandom_range(3, 12)));
         if ($urandom_range(0, 4) == 0) glitch(int'($urandom_range(1, 6)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
